// File: rtl/uc_multicycle.sv
// Multicycle RV32I control unit: Moore FSM driving the shared-ALU datapath plus an instret counter.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT state instead of skipping them.
module uc_multicycle #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       f3,
    input  logic             f7,
    input  logic             zero,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic [1:0]       resSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       inmSrc,
    output logic             regWrite,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       alu_op;
    logic             retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Only the final state of a real instruction retires it; skipped or trapped opcodes never count.
    always_comb begin
        retire = ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ)) && (state_d == S_FETCH);
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_comb begin
        pcWrite  = 1'b0;
        adrSrc   = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        resSrc   = 2'b00;
        aluSrcA  = 2'b00;
        aluSrcB  = 2'b00;
        alu_op   = 2'b00;
        regWrite = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWrite = 1'b1;
                pcWrite = 1'b1;
                aluSrcB = 2'b10;
                resSrc  = 2'b10;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMRD:  adrSrc = 1'b1;
            S_MEMWB: begin
                resSrc   = 2'b01;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECR: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB:  regWrite = 1'b1;
            S_BEQ: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b01;
                pcWrite = zero;
            end
            S_JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcWrite = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT:   illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    // op[5] separates R-type sub from I-type addi, which has no sub form.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  ALUControl = (op[5] & f7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   inmSrc = 2'b01;
            OP_BEQ:  inmSrc = 2'b10;
            OP_JAL:  inmSrc = 2'b11;
            default: inmSrc = 2'b00;
        endcase
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle: per-instruction control-word tables, instret wrap and reset corners.
// A narrow counter is used so the wrap is reached with a short run.
module tb_uc_multicycle;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic             zero;
    logic             pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0]       resSrc, aluSrcA, aluSrcB, inmSrc;
    logic [2:0]       ALUControl;
    logic [CNT_W-1:0] instret;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt;

    typedef struct {
        logic [6:0]       op;
        logic [2:0]       f3;
        logic             f7;
        logic             zero;
        int               n;
        bit               counted;
        logic [4:0][16:0] exp;
    } vec_t;

    vec_t tbl[13];

    uc_multicycle #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ALUControl(ALUControl),
        .inmSrc(inmSrc), .regWrite(regWrite), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic pc, input logic adr, input logic mw,
                                       input logic ir, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] inm,
                                       input logic rw, input logic ill);
        return {pc, adr, mw, ir, res, a, b, alu, inm, rw, ill};
    endfunction

    function automatic logic [16:0] ctl_now();
        return {pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
                ALUControl, inmSrc, regWrite, illegal};
    endfunction

    function automatic logic [16:0] ft(input logic [1:0] inm);
        return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, inm, 0, 0);
    endfunction

    function automatic logic [16:0] dc(input logic [1:0] inm);
        return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, inm, 0, 0);
    endfunction

    function automatic logic [16:0] wb(input logic [1:0] inm);
        return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, inm, 1, 0);
    endfunction

    function automatic vec_t vec(input logic [6:0] o, input logic [2:0] f, input logic s,
                                 input logic z, input int n, input bit c,
                                 input logic [16:0] e0, input logic [16:0] e1,
                                 input logic [16:0] e2, input logic [16:0] e3,
                                 input logic [16:0] e4);
        vec_t v;
        v.op = o; v.f3 = f; v.f7 = s; v.zero = z; v.n = n; v.counted = c;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is in the first cycle of FETCH, before its negedge. Optionally pulse reset
    // after the check of cycle rst_at; otherwise finish in FETCH of the next instruction.
    task automatic run_vec(input vec_t v, input int idx, input int rst_at);
        op = v.op; f3 = v.f3; f7 = v.f7; zero = v.zero;
        for (int c = 0; c < v.n; c++) begin
            @(negedge clk);
            check($sformatf("vec%0d_cyc%0d_ctl", idx, c), 32'(ctl_now()), 32'(v.exp[c]));
            if (c == rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                reset = 1'b0;
                exp_cnt = '0;
                check($sformatf("vec%0d_rst_ctl", idx), 32'(ctl_now()), 32'(ft(ctl_now() >> 2 & 17'h3)));
                check($sformatf("vec%0d_rst_instret", idx), 32'(instret), 32'(exp_cnt));
                return;
            end
        end
        if (v.counted) exp_cnt = exp_cnt + 1'b1;
        check($sformatf("vec%0d_instret", idx), 32'(instret), 32'(exp_cnt));
    endtask

    initial begin
        logic [16:0] z17;
        z17 = '0;
        // op, f3, f7, zero, cycles, counted, control words per cycle
        tbl[0]  = vec(7'b0110011, 3'b000, 0, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,0,0,0), wb(0), z17);
        tbl[1]  = vec(7'b0110011, 3'b000, 1, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0), wb(0), z17);
        tbl[2]  = vec(7'b0110011, 3'b010, 0, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b101,0,0,0), wb(0), z17);
        tbl[3]  = vec(7'b0110011, 3'b110, 0, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b011,0,0,0), wb(0), z17);
        tbl[4]  = vec(7'b0110011, 3'b111, 0, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b010,0,0,0), wb(0), z17);
        tbl[5]  = vec(7'b0010011, 3'b000, 1, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0), wb(0), z17);
        tbl[6]  = vec(7'b0010011, 3'b100, 0, 0, 4, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0), wb(0), z17);
        tbl[7]  = vec(7'b0000011, 3'b010, 0, 0, 5, 1, ft(0), dc(0),
                      mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0),
                      mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0),
                      mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,0,1,0));
        tbl[8]  = vec(7'b0100011, 3'b010, 0, 0, 4, 1, ft(1), dc(1),
                      mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,1,0,0),
                      mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,1,0,0), z17);
        tbl[9]  = vec(7'b1100011, 3'b000, 0, 1, 3, 1, ft(2), dc(2),
                      mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0), z17, z17);
        tbl[10] = vec(7'b1100011, 3'b000, 0, 0, 3, 1, ft(2), dc(2),
                      mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2,0,0), z17, z17);
        tbl[11] = vec(7'b1101111, 3'b000, 0, 0, 4, 1, ft(3), dc(3),
                      mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,3,0,0), wb(3), z17);
        tbl[12] = vec(7'b1111111, 3'b000, 0, 0, 2, 0, ft(0), dc(0), z17, z17, z17);

        reset = 1'b1; op = 7'b0110011; f3 = '0; f7 = 1'b0; zero = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 32'(ctl_now()), 32'(ft(0)));
        check("reset_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Two passes push the 4-bit counter past its wrap point.
        for (int pass = 0; pass < 2; pass++) begin
`ifdef MC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 12; i++) run_vec(tbl[i], pass * 100 + i, -1);
`else
            for (int i = 0; i < 13; i++) run_vec(tbl[i], pass * 100 + i, -1);
`endif
        end

        run_vec(tbl[1], 200, 2);
        run_vec(tbl[0], 201, 3);
        run_vec(tbl[9], 202, -1);

`ifdef MC_ILLEGAL_TRAP_EN
        op = 7'b1111111; f3 = '0; f7 = 1'b0;
        @(negedge clk); check("ill_fetch", 32'(ctl_now()), 32'(ft(0)));
        @(negedge clk); check("ill_decode", 32'(ctl_now()), 32'(dc(0)));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ill_halt%0d", k), 32'(ctl_now()),
                  32'(mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,1)));
        end
        check("ill_instret", 32'(instret), 32'(exp_cnt));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_cnt = '0;
        check("ill_exit_ctl", 32'(ctl_now()), 32'(ft(0)));
        check("ill_exit_instret", 32'(instret), 32'(exp_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
